// File: rtl/four_bit_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package four_bit_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t CALC = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/four_bit_multiplier_add_stage.sv
// One shift-and-add step: conditionally adds the shifted multiplicand to the accumulator.
module mult_add_stage
    import four_bit_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand_sh,
    input  logic               en,
    output logic [2*WIDTH-1:0] acc_next
);

    // The accumulator is 2*WIDTH wide, so the full unsigned product cannot overflow.
    assign acc_next = en ? (acc + mcand_sh) : acc;

endmodule

// File: rtl/four_bit_multiplier.sv
// Sequential unsigned multiplier: one multiplier bit per CALC cycle, LSB first.
module four_bit_multiplier
    import four_bit_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state;
    logic [PW-1:0]    mcand;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    acc_next;
    logic [WIDTH-1:0] mplier;
    logic [CW-1:0]    cnt;

    // mcand is pre-shifted by the iteration index; mplier shifts right so bit 0 is current.
    mult_add_stage #(.WIDTH(WIDTH)) u_add (
        .acc      (acc),
        .mcand_sh (mcand),
        .en       (mplier[0]),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= PW'(a);
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        product <= acc_next;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

endmodule

// File: tb/tb_four_bit_multiplier.sv
// Randomized and directed bench for four_bit_multiplier against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_four_bit_multiplier;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic [2*W-1:0] product;
    logic           busy;
    logic           done;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    four_bit_multiplier #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: m_phase 0 = idle, 1..W = calc cycle number, W+1 = done cycle.
    int m_phase = 0;
    int m_cap   = 0;
    int m_prod  = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_cap   = 0;
            m_prod  = 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_cap   = int'(a) * int'(b);
                m_phase = 1;
            end
        end else if (m_phase < W) begin
            m_phase++;
        end else if (m_phase == W) begin
            m_prod  = m_cap;
            m_phase = W + 1;
        end else begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("busy", busy, (m_phase >= 1 && m_phase <= W));
            check("done", done, (m_phase == W + 1));
            check("product", product, m_prod);
            check("busy_done_excl", busy & done, 0);
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int exp, input string nm);
        int lat  = 0;
        int bcnt = 0;
        bit seen = 1'b0;
        @(posedge clk); #2;
        a = ta; b = tb_v; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) seen = 1'b1;
        end
        check({nm, " done_seen"}, seen, 1);
        check({nm, " latency"}, lat, W + 1);
        check({nm, " busy_cycles"}, bcnt, W);
        check({nm, " product"}, product, exp);
        check({nm, " model"}, m_prod, exp);
    endtask

    task automatic count_dones(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sa[6]  = '{12, 12, 8, 8, 13, 13};
        int sb[6]  = '{3, 5, 5, 7, 7, 13};
        int sp[6]  = '{36, 60, 40, 56, 91, 169};
        int nd;
        int last;
        int ndone;
        bit seen;

        #7;
        check("reset product", product, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        #5 rst_n = 1'b1;
        chk_en = 1'b1;

        run_op(4'd10, 4'd3, 30, "10x3");
        for (int i = 0; i < 6; i++)
            run_op(W'(sa[i]), W'(sb[i]), sp[i], $sformatf("seq%0d", i));

        run_op(4'd0, 4'd15, 0, "0x15");
        run_op(4'd15, 4'd15, 225, "15x15");
        run_op(4'd1, 4'd9, 9, "1x9");
        run_op(4'd15, 4'd1, 15, "15x1");

        // Operands and start disturbed while the operation is running.
        @(posedge clk); #2;
        a = 4'd5; b = 4'd11; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        a = 4'd15; b = 4'd15; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("midcalc done_seen", seen, 1);
        check("midcalc product", product, 55);
        count_dones(8, nd);
        check("midcalc extra_dones", nd, 0);

        // Asynchronous reset in the second CALC cycle.
        @(posedge clk); #2;
        a = 4'd9; b = 4'd9; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        check("prereset busy", busy, 1);
        rst_n = 1'b0;
        #0.5;
        check("abort product", product, 0);
        check("abort busy", busy, 0);
        check("abort done", done, 0);
        #0.5 rst_n = 1'b1;
        count_dones(10, nd);
        check("abort no_done", nd, 0);
        run_op(4'd7, 4'd6, 42, "7x6");

        // start held high with operands changing every cycle.
        @(posedge clk); #2;
        start = 1'b1;
        last  = -1;
        ndone = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #2;
            a = W'($urandom_range(15));
            b = W'($urandom_range(15));
            @(negedge clk);
            if (done) begin
                if (last >= 0) check("held gap", i - last, W + 2);
                last = i;
                ndone++;
            end
        end
        check("held count", (ndone >= 7), 1);
        start = 1'b0;
        repeat (8) @(posedge clk);

        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #2;
            start = ($urandom_range(2) == 0);
            a = W'($urandom_range(15));
            b = W'($urandom_range(15));
        end
        start = 1'b0;
        repeat (8) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/four_bit_multiplier.md
FOUR_BIT_MULTIPLIER -- requirements
Module: four_bit_multiplier

Interface
- REQ-001: Parameter WIDTH, default 4, operand width in bits; product width SHALL be 2*WIDTH.
- REQ-002: clk  input  1  single clock; all state SHALL update on the rising edge.
- REQ-003: rst_n  input  1  asynchronous, active-low reset.
- REQ-004: start  input  1  request pulse; SHALL be sampled only in IDLE.
- REQ-005: a  input  WIDTH  multiplicand, unsigned.
- REQ-006: b  input  WIDTH  multiplier, unsigned.
- REQ-007: product  output  2*WIDTH  registered unsigned result a*b.
- REQ-008: busy  output  1  high while a multiplication is in progress (CALC state).
- REQ-009: done  output  1  one-cycle pulse marking product valid.

Function
- REQ-010: The block SHALL be a sequential shift-and-add multiplier with FSM states IDLE, CALC, DONE.
- REQ-011: IDLE with start=1 at a rising edge SHALL capture a and b into internal registers, clear the accumulator and iteration counter, and go to CALC.
- REQ-012: Each CALC edge SHALL examine one multiplier bit, LSB first; if the bit is 1, it SHALL add the multiplicand, shifted left by the iteration index, to the 2*WIDTH-bit accumulator.
- REQ-013: CALC SHALL last exactly WIDTH cycles (4 by default); after the last iteration the accumulator SHALL be copied to product and the state SHALL go to DONE.
- REQ-014: done SHALL be 1 only during the single DONE cycle; DONE SHALL return to IDLE unconditionally on the next edge.
- REQ-015: Latency SHALL be fixed at WIDTH+1 edges from the edge that samples start to the edge that asserts done (5 for WIDTH=4).
- REQ-016: product SHALL hold its last value until the next completion; it SHALL not change during CALC.
- REQ-017: start SHALL be ignored in CALC and DONE; a and b changes after capture SHALL NOT affect the running result.
- REQ-018: Arithmetic SHALL be unsigned and exact; the maximum result (2^WIDTH-1)^2 SHALL fit in 2*WIDTH bits with no overflow or truncation.
- REQ-019: busy SHALL be 1 exactly in CALC; busy and done SHALL never both be 1.
- REQ-020: start held high continuously SHALL begin a new operation on each return to IDLE, giving one result every WIDTH+2 cycles.

Reset
- REQ-021: rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, product=0, busy=0, done=0, and clear the accumulator, counter and operand registers.
- REQ-022: Reset asserted mid-CALC SHALL abort the operation; no done pulse for it SHALL follow, and product SHALL read 0.
- REQ-023: After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Structure
- REQ-024: A shared package SHALL hold the FSM state enumeration (IDLE, CALC, DONE) and the default WIDTH constant.
- REQ-025: The multiplicand-shift/conditional-add datapath SHALL be a single sub-module, mult_add_stage: inputs accumulator, shifted multiplicand and bit enable; output next accumulator. Control, counter and output registers SHALL stay in the top module.

Verification
- REQ-026: a=10, b=3, start pulse -> done after 5 edges, product=30 (8'h1E); busy high for exactly 4 cycles.
- REQ-027: Sequence 12*3, 12*5, 8*5, 8*7, 13*7, 13*13 -> products 36, 60, 40, 56, 91, 169 (8'hA9), one done pulse each.
- REQ-028: Boundaries: 0*15 -> 0; 15*15 -> 225 (8'hE1); 1*9 -> 9; 15*1 -> 15.
- REQ-029: Change a and b and pulse start during CALC -> result reflects the originally captured operands; the extra start is ignored.
- REQ-030: rst_n low for 1 ns in the 2nd CALC cycle -> outputs 0 at once, no done pulse; the next start 7*6 -> 42.
- REQ-031: start held high -> done pulses every 6 cycles with a correct product each time.
